// File: rtl/id_pkg.sv
// Shared decode-stage codes: write-back source select, immediate formats, immediate builder.
// No latency (types and a pure function only).
// No backpressure (no storage).
package id_pkg;

  // Write-back data source select
  typedef enum logic [1:0] {
    WSEL_ALU = 2'd0,
    WSEL_PC4 = 2'd1,
    WSEL_EXT = 2'd2,
    WSEL_RDO = 2'd3
  } rf_wsel_e;

  // Immediate format select
  typedef enum logic [2:0] {
    SEXT_I = 3'd0,
    SEXT_S = 3'd1,
    SEXT_B = 3'd2,
    SEXT_U = 3'd3,
    SEXT_J = 3'd4
  } sext_op_e;

  localparam int REG_IDX_W = 5;

  // Builds the 32-bit sign-extended immediate; unused format codes give 0.
  function automatic logic [31:0] sext_imm(input logic [31:0] inst, input logic [2:0] op);
    logic [31:0] imm;
    imm = '0;
    case (op)
      SEXT_I:  imm = {{20{inst[31]}}, inst[31:20]};
      SEXT_S:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      SEXT_B:  imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      SEXT_U:  imm = {inst[31:12], 12'b0};
      SEXT_J:  imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_pipe_if.sv
// Bundles the IF->ID offer, EX feedback, write-back request and ID/EX payload.
// No latency (wires only).
// id_ready is the only backpressure signal towards IF; ex_ready comes back from EX.
interface id_pipe_if #(
  parameter int XLEN = 32
) ();
  logic            if_valid;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;
  logic [2:0]      sext_op;
  logic            flush;
  logic            ex_ready;
  logic            ex_is_load;
  logic [4:0]      ex_rd_in;
  logic            wb_we;
  logic [4:0]      wb_wr;
  logic [1:0]      wb_wsel;
  logic [XLEN-1:0] wb_alu_c;
  logic [XLEN-1:0] wb_pc4;
  logic [XLEN-1:0] wb_ext;
  logic [XLEN-1:0] wb_rdo;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rd1;
  logic [XLEN-1:0] ex_rd2;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] dbg_rf_wd;

  // Decode stage side
  modport slave (
    input  if_valid, if_inst, if_pc, sext_op, flush, ex_ready, ex_is_load, ex_rd_in,
    input  wb_we, wb_wr, wb_wsel, wb_alu_c, wb_pc4, wb_ext, wb_rdo,
    output id_ready, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
    output dbg_rf_wd
  );

  // Surrounding pipeline side
  modport master (
    output if_valid, if_inst, if_pc, sext_op, flush, ex_ready, ex_is_load, ex_rd_in,
    output wb_we, wb_wr, wb_wsel, wb_alu_c, wb_pc4, wb_ext, wb_rdo,
    input  id_ready, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
    input  dbg_rf_wd
  );
endinterface

// File: rtl/id_regfile.sv
// Register file, 2 combinational read ports, 1 write port; x0 hardwired to zero. Macro: ID_WB_BYPASS_EN.
// Write lands on the clock edge; reads are combinational (write-first when ID_WB_BYPASS_EN is defined).
// No backpressure: a write is always accepted.
module id_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i,
  input  logic [4:0]      ra1_i,
  input  logic [4:0]      ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] regs_q [NREG];
  logic [AW-1:0]   wa_idx;
  logic [AW-1:0]   ra1_idx;
  logic [AW-1:0]   ra2_idx;
  logic            wr_en;

  // Only the low index bits select a register; upper field bits are ignored.
  assign wa_idx  = wa_i[AW-1:0];
  assign ra1_idx = ra1_i[AW-1:0];
  assign ra2_idx = ra2_i[AW-1:0];
  assign wr_en   = we_i && (wa_idx != '0);

  // Storage: cleared by reset, written when the write targets a nonzero register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wa_idx] <= wd_i;
    end
  end

  // Read ports: x0 reads zero; optional forwarding of the same-cycle write
  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    if (ra1_idx != '0) rd1_o = regs_q[ra1_idx];
    if (ra2_idx != '0) rd2_o = regs_q[ra2_idx];
`ifdef ID_WB_BYPASS_EN
    if (wr_en && (ra1_idx == wa_idx)) rd1_o = wd_i;
    if (wr_en && (ra2_idx == wa_idx)) rd2_o = wd_i;
`endif
  end

endmodule

// File: rtl/id_pipe.sv
// Instruction decode stage: register read, immediate build, load-use interlock, ID/EX register. Macro: ID_WB_BYPASS_EN.
// Latency 1 cycle from accepted IF offer to ex_valid.
// Holds ID/EX while EX stalls; deasserts id_ready on stall or load-use hazard; flush always wins.
module id_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic     clk,
  input logic     rst_n,
  id_pipe_if.slave bus
);
  import id_pkg::*;

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic [XLEN-1:0] wb_wd;
  logic [31:0]     imm32;
  logic            hazard;
  logic            ex_free;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q,    ex_pc_d;
  logic [XLEN-1:0] ex_rd1_q,   ex_rd1_d;
  logic [XLEN-1:0] ex_rd2_q,   ex_rd2_d;
  logic [XLEN-1:0] ex_imm_q,   ex_imm_d;
  logic [4:0]      ex_rs1_q,   ex_rs1_d;
  logic [4:0]      ex_rs2_q,   ex_rs2_d;
  logic [4:0]      ex_rd_q,    ex_rd_d;

  assign rs1   = bus.if_inst[19:15];
  assign rs2   = bus.if_inst[24:20];
  assign rd    = bus.if_inst[11:7];
  assign imm32 = sext_imm(bus.if_inst, bus.sext_op);

  // Write-back source mux
  always_comb begin
    wb_wd = bus.wb_alu_c;
    case (rf_wsel_e'(bus.wb_wsel))
      WSEL_ALU: wb_wd = bus.wb_alu_c;
      WSEL_PC4: wb_wd = bus.wb_pc4;
      WSEL_EXT: wb_wd = bus.wb_ext;
      WSEL_RDO: wb_wd = bus.wb_rdo;
      default:  wb_wd = bus.wb_alu_c;
    endcase
  end

  id_regfile #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (bus.wb_we),
    .wa_i  (bus.wb_wr),
    .wd_i  (wb_wd),
    .ra1_i (rs1),
    .ra2_i (rs2),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2)
  );

  // A load in EX whose result feeds the offered instruction cannot be forwarded in time.
  assign hazard = bus.if_valid && ex_valid_q && bus.ex_is_load && (bus.ex_rd_in != 5'd0) &&
                  ((bus.ex_rd_in == rs1) || (bus.ex_rd_in == rs2));
  assign ex_free = bus.ex_ready || !ex_valid_q;

  assign bus.id_ready  = bus.flush || (!hazard && ex_free);
  assign bus.dbg_rf_wd = wb_wd;

  // ID/EX next state: flush kills, EX stall holds, hazard inserts a bubble, otherwise accept
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_rd1_d   = ex_rd1_q;
    ex_rd2_d   = ex_rd2_q;
    ex_imm_d   = ex_imm_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_rd_d    = ex_rd_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (ex_free) begin
      if (bus.if_valid && !hazard) begin
        ex_valid_d = 1'b1;
        ex_pc_d    = bus.if_pc;
        ex_rd1_d   = rf_rd1;
        ex_rd2_d   = rf_rd2;
        ex_imm_d   = XLEN'($signed(imm32));
        ex_rs1_d   = rs1;
        ex_rs2_d   = rs2;
        ex_rd_d    = rd;
      end else begin
        ex_valid_d = 1'b0;
      end
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_rd1_q   <= '0;
      ex_rd2_q   <= '0;
      ex_imm_q   <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_rd1_q   <= ex_rd1_d;
      ex_rd2_q   <= ex_rd2_d;
      ex_imm_q   <= ex_imm_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_pc    = ex_pc_q;
  assign bus.ex_rd1   = ex_rd1_q;
  assign bus.ex_rd2   = ex_rd2_q;
  assign bus.ex_imm   = ex_imm_q;
  assign bus.ex_rs1   = ex_rs1_q;
  assign bus.ex_rs2   = ex_rs2_q;
  assign bus.ex_rd    = ex_rd_q;

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: immediate/field table plus hand-written write-back, hazard, stall, bypass and reset sequences.
module tb_id_pipe;
  import id_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  id_pipe_if #(.XLEN(32)) bus ();

  id_pipe #(.XLEN(32), .NREG(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'h0000_00AB;
`else
  localparam logic [31:0] BYP_EXP = 32'h0000_0011;
`endif

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  op;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } vec_t;

  localparam int NV = 11;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.if_valid   = 1'b0;
    bus.if_inst    = 32'h0000_0013;
    bus.if_pc      = '0;
    bus.sext_op    = SEXT_I;
    bus.flush      = 1'b0;
    bus.ex_ready   = 1'b1;
    bus.ex_is_load = 1'b0;
    bus.ex_rd_in   = 5'd0;
    bus.wb_we      = 1'b0;
    bus.wb_wr      = 5'd0;
    bus.wb_wsel    = WSEL_ALU;
    bus.wb_alu_c   = '0;
    bus.wb_pc4     = '0;
    bus.wb_ext     = '0;
    bus.wb_rdo     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
  endtask

  initial begin
    logic [31:0] wexp [4];
    logic [4:0]  rr;
    total = 0;
    bad   = 0;

    vec[0]  = '{32'hFFF10093, SEXT_I, 32'hFFFF_FFFF, 5'd2, 5'd31, 5'd1};
    vec[1]  = '{32'h7FF20193, SEXT_I, 32'h0000_07FF, 5'd4, 5'd31, 5'd3};
    vec[2]  = '{32'h00532423, SEXT_S, 32'h0000_0008, 5'd6, 5'd5,  5'd8};
    vec[3]  = '{32'hFE532E23, SEXT_S, 32'hFFFF_FFFC, 5'd6, 5'd5,  5'd28};
    vec[4]  = '{32'h00208863, SEXT_B, 32'h0000_0010, 5'd1, 5'd2,  5'd16};
    vec[5]  = '{32'hFE208FE3, SEXT_B, 32'hFFFF_FFFE, 5'd1, 5'd2,  5'd31};
    vec[6]  = '{32'h123452B7, SEXT_U, 32'h1234_5000, 5'd8, 5'd3,  5'd5};
    vec[7]  = '{32'h800000B7, SEXT_U, 32'h8000_0000, 5'd0, 5'd0,  5'd1};
    vec[8]  = '{32'h001000EF, SEXT_J, 32'h0000_0800, 5'd0, 5'd1,  5'd1};
    vec[9]  = '{32'hFFFFF06F, SEXT_J, 32'hFFFF_FFFE, 5'd31, 5'd31, 5'd0};
    vec[10] = '{32'hFFF10093, 3'd7,   32'h0000_0000, 5'd2, 5'd31, 5'd1};

    // Reset state
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_ex_pc",    bus.ex_pc,  32'd0);
    chk("rst_ex_rd1",   bus.ex_rd1, 32'd0);
    chk("rst_ex_rd2",   bus.ex_rd2, 32'd0);
    chk("rst_ex_imm",   bus.ex_imm, 32'd0);
    chk("rst_ex_rs1",   {27'd0, bus.ex_rs1}, 32'd0);
    chk("rst_ex_rs2",   {27'd0, bus.ex_rs2}, 32'd0);
    chk("rst_ex_rd",    {27'd0, bus.ex_rd},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Immediate formats and register fields
    for (int i = 0; i < NV; i++) begin
      issue(vec[i].inst, 32'h0000_0100 + 32'(i * 4));
      bus.sext_op = vec[i].op;
      tick();
      chk($sformatf("tbl%0d_valid", i), {31'd0, bus.ex_valid}, 32'd1);
      chk($sformatf("tbl%0d_imm", i), bus.ex_imm, vec[i].imm);
      chk($sformatf("tbl%0d_rs1", i), {27'd0, bus.ex_rs1}, {27'd0, vec[i].rs1});
      chk($sformatf("tbl%0d_rs2", i), {27'd0, bus.ex_rs2}, {27'd0, vec[i].rs2});
      chk($sformatf("tbl%0d_rd", i),  {27'd0, bus.ex_rd},  {27'd0, vec[i].rd});
      chk($sformatf("tbl%0d_pc", i),  bus.ex_pc, 32'h0000_0100 + 32'(i * 4));
    end
    idle();
    tick();
    chk("idle_bubble", {31'd0, bus.ex_valid}, 32'd0);

    // Write-back source select
    bus.wb_alu_c = 32'hA1A1_A1A1;
    bus.wb_pc4   = 32'hB2B2_B2B2;
    bus.wb_ext   = 32'hC3C3_C3C3;
    bus.wb_rdo   = 32'hD4D4_D4D4;
    wexp[0] = 32'hA1A1_A1A1;
    wexp[1] = 32'hB2B2_B2B2;
    wexp[2] = 32'hC3C3_C3C3;
    wexp[3] = 32'hD4D4_D4D4;
    for (int i = 0; i < 4; i++) begin
      bus.wb_wsel = 2'(i);
      #1;
      chk($sformatf("wsel%0d", i), bus.dbg_rf_wd, wexp[i]);
    end
    idle();

    // x5 = 0x1234, then add x6,x5,x0
    bus.wb_we = 1'b1; bus.wb_wr = 5'd5; bus.wb_wsel = WSEL_ALU; bus.wb_alu_c = 32'h0000_1234;
    tick();
    idle();
    issue(32'h00028333, 32'h0000_0200);
    tick();
    chk("add_x5_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("add_x5_rd1",   bus.ex_rd1, 32'h0000_1234);
    chk("add_x5_rd2",   bus.ex_rd2, 32'd0);

    // Write to x0 is dropped
    idle();
    bus.wb_we = 1'b1; bus.wb_wr = 5'd0; bus.wb_wsel = WSEL_ALU; bus.wb_alu_c = 32'hFFFF_FFFF;
    #1;
    chk("x0_wd", bus.dbg_rf_wd, 32'hFFFF_FFFF);
    tick();
    idle();
    issue(32'h00000333, 32'h0000_0204);
    tick();
    chk("x0_rd1", bus.ex_rd1, 32'd0);

    // Load-use hazard on rs2
    idle();
    issue(32'h00000333, 32'h0000_0300);
    tick();
    chk("hz_pre_valid", {31'd0, bus.ex_valid}, 32'd1);
    issue(32'h00708433, 32'h0000_0304);
    bus.ex_is_load = 1'b1; bus.ex_rd_in = 5'd7;
    #1;
    chk("hz_id_ready", {31'd0, bus.id_ready}, 32'd0);
    tick();
    chk("hz_bubble", {31'd0, bus.ex_valid}, 32'd0);
    chk("hz_clear_ready", {31'd0, bus.id_ready}, 32'd1);
    tick();
    chk("hz_issue_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("hz_issue_pc",    bus.ex_pc, 32'h0000_0304);
    chk("hz_issue_rs2",   {27'd0, bus.ex_rs2}, 32'd7);
    chk("hz_issue_rd",    {27'd0, bus.ex_rd},  32'd8);

    // Matching register but not a load: no interlock
    bus.ex_is_load = 1'b0;
    #1;
    chk("noload_ready", {31'd0, bus.id_ready}, 32'd1);

    // EX stall for 3 cycles, then flush during the stall
    bus.ex_ready = 1'b0;
    issue(32'h00000333, 32'h0000_0308);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_ready", c), {31'd0, bus.id_ready}, 32'd0);
      tick();
      chk($sformatf("stall%0d_valid", c), {31'd0, bus.ex_valid}, 32'd1);
      chk($sformatf("stall%0d_pc", c),    bus.ex_pc, 32'h0000_0304);
      chk($sformatf("stall%0d_rd", c),    {27'd0, bus.ex_rd}, 32'd8);
    end
    bus.flush = 1'b1;
    #1;
    chk("flush_ready", {31'd0, bus.id_ready}, 32'd1);
    tick();
    chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);

    // Same-cycle write/read of x9
    idle();
    bus.wb_we = 1'b1; bus.wb_wr = 5'd9; bus.wb_wsel = WSEL_PC4; bus.wb_pc4 = 32'h0000_0011;
    tick();
    idle();
    bus.wb_we = 1'b1; bus.wb_wr = 5'd9; bus.wb_wsel = WSEL_EXT; bus.wb_ext = 32'h0000_00AB;
    issue(32'h00948533, 32'h0000_0400);
    tick();
    chk("byp_rd1", bus.ex_rd1, BYP_EXP);
    chk("byp_rd2", bus.ex_rd2, BYP_EXP);
    idle();
    issue(32'h00948533, 32'h0000_0404);
    tick();
    chk("after_byp_rd1", bus.ex_rd1, 32'h0000_00AB);

    // Asynchronous reset between edges
    idle();
    issue(32'h00028333, 32'h0000_0500);
    tick();
    chk("prerst_valid", {31'd0, bus.ex_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("arst_pc",    bus.ex_pc, 32'd0);
    chk("arst_rd1",   bus.ex_rd1, 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 1; r < 32; r++) begin
      rr = 5'(r);
      issue({7'd0, rr, rr, 3'd0, 5'd0, 7'h33}, 32'h0000_0600 + 32'(r * 4));
      tick();
      chk($sformatf("post_rst_x%0d_rd1", r), bus.ex_rd1, 32'd0);
      chk($sformatf("post_rst_x%0d_rd2", r), bus.ex_rd2, 32'd0);
      if (r == 1) chk("post_rst_first_valid", {31'd0, bus.ex_valid}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 SHALL have parameters: XLEN, default 32, datapath width; NREG, default 32, register count (power of two, 2..32).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports if_valid input 1, if_inst input 32, if_pc input XLEN: instruction offered by IF.
REQ-005 SHALL have port id_ready, output, 1: ID accepts the offered instruction this cycle.
REQ-006 SHALL have ports sext_op input 3 and flush input 1: immediate-format select and redirect kill.
REQ-007 SHALL have ports ex_ready input 1, ex_is_load input 1, ex_rd_in input 5: EX backpressure and the load-destination tag of the instruction currently in EX.
REQ-008 SHALL have ports wb_we input 1, wb_wr input 5, wb_wsel input 2, wb_alu_c, wb_pc4, wb_ext, wb_rdo input XLEN each: write-back request.
REQ-009 SHALL have outputs ex_valid 1, ex_pc XLEN, ex_rd1 XLEN, ex_rd2 XLEN, ex_imm XLEN, ex_rs1 5, ex_rs2 5, ex_rd 5: registered ID/EX payload.
REQ-010 SHALL have output dbg_rf_wd, XLEN: selected write-back data, debug only.

Function
REQ-011 SHALL select write data by wb_wsel: ALU->wb_alu_c, PC4->wb_pc4, EXT->wb_ext, RDO->wb_rdo; no other code exists.
REQ-012 SHALL write the register file on the clk edge when wb_we=1 and wb_wr!=0; register 0 always reads 0.
REQ-013 SHALL index only the low log2(NREG) bits of register fields; higher bits ignored.
REQ-014 SHALL read rs1=if_inst[19:15], rs2=if_inst[24:20] combinationally; rd=if_inst[11:7].
REQ-015 SHALL sign/zero-extend the immediate per sext_op (I, S, B, U, J formats) to XLEN.
REQ-016 SHALL assert load-use hazard when ex_valid=1, ex_is_load=1, ex_rd_in!=0 and ex_rd_in equals rs1 or rs2 of a valid if_inst.
REQ-017 SHALL drive id_ready = !hazard && (ex_ready || !ex_valid), or 1 when flush=1.
REQ-018 SHALL, on an edge with if_valid && id_ready && !flush, load payload and set ex_valid=1 (latency 1 cycle).
REQ-019 SHALL, on hazard with ex_ready=1, load a bubble (ex_valid=0) and hold IF.
REQ-020 SHALL, when ex_valid=1 and ex_ready=0, hold all ex_* outputs unchanged.
REQ-021 SHALL, on flush=1, clear ex_valid next edge regardless of stall, hazard or ex_ready.

Reset
REQ-022 SHALL, while rst_n=0, force ex_valid=0 and all other ex_* outputs and all registers to 0, asynchronously.
REQ-023 SHALL resume accepting on the first edge after rst_n rises; an instruction in flight at reset is lost.

Configuration
REQ-024 SHALL implement write-first bypass under macro ID_WB_BYPASS_EN: defined -> a same-cycle write to rs1/rs2 (nonzero) returns the new write data; undefined -> reads return the pre-write value.

Structure
REQ-025 SHALL take RF_WSEL and SEXT_OP codes from shared package id_pkg.
REQ-026 SHALL instantiate the register file as sub-module id_regfile (params XLEN, NREG, two read ports, one write port).

Verification
REQ-027 Write x5=0x1234 via wsel ALU, then decode "add x6,x5,x0" -> next cycle ex_rd1=0x1234, ex_valid=1.
REQ-028 wb_we=1, wb_wr=0, data 0xFFFF_FFFF, then read x0 -> ex_rd1=0.
REQ-029 ex_valid=1, ex_is_load=1, ex_rd_in=7, if_inst uses rs2=7 -> id_ready=0, one bubble, instruction issues the following cycle once hazard clears.
REQ-030 ex_valid=1, ex_ready=0 for 3 cycles -> ex_* stable, id_ready=0; flush=1 during stall -> ex_valid=0 next edge.
REQ-031 Same-cycle write x9=0xAB and read x9 -> 0xAB with ID_WB_BYPASS_EN, old value without.
REQ-032 Assert rst_n=0 mid-stream between edges -> ex_valid=0 immediately, x1..x31 read 0 after release.
